rvc_asap_top_5pl: RTL and testbench

- Top level of the 5-stage pipelined RV32I core: the pipeline plus a memory wrapper holding a byte-addressed instruction memory and data memory.
- Self-contained; the only external pins are clock and reset.
- Program and data images are backdoor-loaded into the memory arrays.
- End of program is the EBREAK instruction (0x00100073) reaching the decode-stage instruction register.

---
 rtl/rvc_asap_top_5pl.sv | 251 +++++++++++++++++++++++++
 tb/tb_rvc_asap_top_5pl.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/rvc_asap_top_5pl.sv
// Five-stage pipelined RV32I core with byte-addressed instruction and data memories.
// Fetch Q100H, decode Q101H, execute Q102H, memory Q103H, writeback Q104H.
module rvc_asap_top_5pl #(
   parameter int I_MEM_MSB = 'h0FFF,
   parameter int D_MEM_MSB = 'h1FFF
) (
   input logic Clock,
   input logic Rst
);

   localparam logic [31:0] NOP      = 32'h0000_0013;
   localparam int          IA_W     = $clog2(I_MEM_MSB + 1);
   localparam int          DA_W     = $clog2(D_MEM_MSB + 1);
   localparam logic [6:0]  OP_LUI   = 7'b0110111;
   localparam logic [6:0]  OP_AUIPC = 7'b0010111;
   localparam logic [6:0]  OP_JAL   = 7'b1101111;
   localparam logic [6:0]  OP_JALR  = 7'b1100111;
   localparam logic [6:0]  OP_BR    = 7'b1100011;
   localparam logic [6:0]  OP_LOAD  = 7'b0000011;
   localparam logic [6:0]  OP_STORE = 7'b0100011;
   localparam logic [6:0]  OP_IMM   = 7'b0010011;
   localparam logic [6:0]  OP_OP    = 7'b0110011;

   logic [7:0]  IMem [I_MEM_MSB:0];
   logic [7:0]  DMem [D_MEM_MSB:I_MEM_MSB+1];
   logic [31:0] r_regs [31:0];

   logic [31:0] r_pc_q100;
   logic [31:0] InstructionQ101H, r_pc_q101;
   logic        r_valid_q101;
   logic [31:0] r_instr_q102, r_pc_q102, r_rs1_q102, r_rs2_q102;
   logic        r_valid_q102;
   logic [31:0] r_instr_q103, r_alu_q103, r_st_q103;
   logic        r_valid_q103;
   logic [31:0] r_instr_q104, r_wb_q104;
   logic        r_valid_q104;

   function automatic logic f_wen(input logic [31:0] ins);
      logic [6:0] op;
      op = ins[6:0];
      return (ins[11:7] != 5'd0) &&
             (op == OP_LUI || op == OP_AUIPC || op == OP_JAL || op == OP_JALR ||
              op == OP_LOAD || op == OP_IMM || op == OP_OP);
   endfunction

   function automatic logic f_use_rs1(input logic [6:0] op);
      return op == OP_JALR || op == OP_BR || op == OP_LOAD || op == OP_STORE ||
             op == OP_IMM || op == OP_OP;
   endfunction

   function automatic logic f_use_rs2(input logic [6:0] op);
      return op == OP_BR || op == OP_STORE || op == OP_OP;
   endfunction

   function automatic logic f_in_dmem(input logic [31:0] a);
      return (a >= 32'(I_MEM_MSB + 1)) && (a <= 32'(D_MEM_MSB));
   endfunction

   function automatic logic [7:0] f_imem_rd(input logic [31:0] a);
      if (a <= 32'(I_MEM_MSB)) return IMem[a[IA_W-1:0]];
      return 8'h00;
   endfunction

   function automatic logic [7:0] f_dmem_rd(input logic [31:0] a);
      if (f_in_dmem(a)) return DMem[a[DA_W-1:0]];
      return 8'h00;
   endfunction

   function automatic logic [31:0] f_alu(input logic [2:0] f3, input logic alt,
                                         input logic [31:0] a, input logic [31:0] b);
      case (f3)
         3'b000:  return alt ? a - b : a + b;
         3'b001:  return a << b[4:0];
         3'b010:  return {31'd0, $signed(a) < $signed(b)};
         3'b011:  return {31'd0, a < b};
         3'b100:  return a ^ b;
         3'b101:  return alt ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
         3'b110:  return a | b;
         default: return a & b;
      endcase
   endfunction

   logic w_wen_q103, w_wen_q104;
   assign w_wen_q103 = r_valid_q103 && f_wen(r_instr_q103);
   assign w_wen_q104 = r_valid_q104 && f_wen(r_instr_q104);

   // Q100H/Q101H: fetch, regfile read with same-cycle writeback bypass, load-use detect
   logic [31:0] w_fetch, w_rf_rs1, w_rf_rs2;
   logic [4:0]  w_rs1_q101, w_rs2_q101;
   logic        w_stall;

   assign w_fetch = (r_pc_q100 > 32'(I_MEM_MSB)) ? 32'd0 :
                    {f_imem_rd(r_pc_q100 + 32'd3), f_imem_rd(r_pc_q100 + 32'd2),
                     f_imem_rd(r_pc_q100 + 32'd1), f_imem_rd(r_pc_q100)};
   assign w_rs1_q101 = InstructionQ101H[19:15];
   assign w_rs2_q101 = InstructionQ101H[24:20];
   assign w_rf_rs1 = (w_rs1_q101 == 5'd0) ? 32'd0 :
                     (w_wen_q104 && r_instr_q104[11:7] == w_rs1_q101) ? r_wb_q104 :
                     r_regs[w_rs1_q101];
   assign w_rf_rs2 = (w_rs2_q101 == 5'd0) ? 32'd0 :
                     (w_wen_q104 && r_instr_q104[11:7] == w_rs2_q101) ? r_wb_q104 :
                     r_regs[w_rs2_q101];
   assign w_stall = r_valid_q102 && (r_instr_q102[6:0] == OP_LOAD) && (r_instr_q102[11:7] != 5'd0) &&
                    ((f_use_rs1(InstructionQ101H[6:0]) && w_rs1_q101 == r_instr_q102[11:7]) ||
                     (f_use_rs2(InstructionQ101H[6:0]) && w_rs2_q101 == r_instr_q102[11:7]));

   // Q102H: operand forwarding, ALU, branch resolve
   logic [4:0]  w_rs1_q102, w_rs2_q102;
   logic [31:0] w_a, w_b, w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j, w_res, w_target;
   logic        w_taken, w_cond;

   assign w_rs1_q102 = r_instr_q102[19:15];
   assign w_rs2_q102 = r_instr_q102[24:20];
   assign w_a = (w_rs1_q102 == 5'd0) ? 32'd0 :
                (w_wen_q103 && r_instr_q103[11:7] == w_rs1_q102) ? r_alu_q103 :
                (w_wen_q104 && r_instr_q104[11:7] == w_rs1_q102) ? r_wb_q104 : r_rs1_q102;
   assign w_b = (w_rs2_q102 == 5'd0) ? 32'd0 :
                (w_wen_q103 && r_instr_q103[11:7] == w_rs2_q102) ? r_alu_q103 :
                (w_wen_q104 && r_instr_q104[11:7] == w_rs2_q102) ? r_wb_q104 : r_rs2_q102;
   assign w_imm_i = {{20{r_instr_q102[31]}}, r_instr_q102[31:20]};
   assign w_imm_s = {{20{r_instr_q102[31]}}, r_instr_q102[31:25], r_instr_q102[11:7]};
   assign w_imm_b = {{19{r_instr_q102[31]}}, r_instr_q102[31], r_instr_q102[7],
                     r_instr_q102[30:25], r_instr_q102[11:8], 1'b0};
   assign w_imm_u = {r_instr_q102[31:12], 12'd0};
   assign w_imm_j = {{11{r_instr_q102[31]}}, r_instr_q102[31], r_instr_q102[19:12],
                     r_instr_q102[20], r_instr_q102[30:21], 1'b0};

   always_comb begin
      w_res    = 32'd0;
      w_taken  = 1'b0;
      w_cond   = 1'b0;
      w_target = r_pc_q102 + w_imm_b;
      case (r_instr_q102[14:12])
         3'b000:  w_cond = (w_a == w_b);
         3'b001:  w_cond = (w_a != w_b);
         3'b100:  w_cond = ($signed(w_a) < $signed(w_b));
         3'b101:  w_cond = ($signed(w_a) >= $signed(w_b));
         3'b110:  w_cond = (w_a < w_b);
         3'b111:  w_cond = (w_a >= w_b);
         default: w_cond = 1'b0;
      endcase
      case (r_instr_q102[6:0])
         OP_LUI:   w_res = w_imm_u;
         OP_AUIPC: w_res = r_pc_q102 + w_imm_u;
         OP_JAL: begin
            w_res    = r_pc_q102 + 32'd4;
            w_taken  = r_valid_q102;
            w_target = r_pc_q102 + w_imm_j;
         end
         OP_JALR: begin
            w_res    = r_pc_q102 + 32'd4;
            w_taken  = r_valid_q102;
            w_target = (w_a + w_imm_i) & ~32'd1;
         end
         OP_BR:    w_taken = r_valid_q102 && w_cond;
         OP_LOAD:  w_res = w_a + w_imm_i;
         OP_STORE: w_res = w_a + w_imm_s;
         OP_IMM:   w_res = f_alu(r_instr_q102[14:12],
                                 (r_instr_q102[14:12] == 3'b101) && r_instr_q102[30], w_a, w_imm_i);
         OP_OP:    w_res = f_alu(r_instr_q102[14:12], r_instr_q102[30], w_a, w_b);
         default:  w_res = 32'd0;
      endcase
   end

   // Q103H: data memory access; out-of-window bytes read as 0 and drop writes
   logic [31:0] w_ld_raw, w_ld_data;
   logic [31:0] w_st_addr [4];
   logic [3:0]  w_st_en;
   logic [2:0]  w_st_nb;

   always_comb begin
      w_ld_raw = 32'd0;
      w_st_en  = 4'd0;
      w_st_nb  = (r_instr_q103[13:12] == 2'b00) ? 3'd1 :
                 (r_instr_q103[13:12] == 2'b01) ? 3'd2 : 3'd4;
      for (int k = 0; k < 4; k++) begin
         w_st_addr[k]      = r_alu_q103 + 32'(k);
         w_ld_raw[8*k +: 8] = f_dmem_rd(w_st_addr[k]);
         w_st_en[k]        = r_valid_q103 && (r_instr_q103[6:0] == OP_STORE) &&
                             (3'(k) < w_st_nb) && f_in_dmem(w_st_addr[k]);
      end
      case (r_instr_q103[14:12])
         3'b000:  w_ld_data = {{24{w_ld_raw[7]}}, w_ld_raw[7:0]};
         3'b001:  w_ld_data = {{16{w_ld_raw[15]}}, w_ld_raw[15:0]};
         3'b100:  w_ld_data = {24'd0, w_ld_raw[7:0]};
         3'b101:  w_ld_data = {16'd0, w_ld_raw[15:0]};
         default: w_ld_data = w_ld_raw;
      endcase
   end

   always_ff @(posedge Clock) begin
      if (!Rst) begin
         for (int k = 0; k < 4; k++)
            if (w_st_en[k]) DMem[w_st_addr[k][DA_W-1:0]] <= r_st_q103[8*k +: 8];
      end
   end

   always_ff @(posedge Clock) begin
      if (!Rst && w_wen_q104) r_regs[r_instr_q104[11:7]] <= r_wb_q104;
   end

   always_ff @(posedge Clock) begin
      if (Rst) begin
         r_pc_q100        <= 32'd0;
         InstructionQ101H <= NOP;
         r_pc_q101        <= 32'd0;
         r_valid_q101     <= 1'b0;
         r_instr_q102     <= NOP;
         r_pc_q102        <= 32'd0;
         r_rs1_q102       <= 32'd0;
         r_rs2_q102       <= 32'd0;
         r_valid_q102     <= 1'b0;
         r_instr_q103     <= NOP;
         r_alu_q103       <= 32'd0;
         r_st_q103        <= 32'd0;
         r_valid_q103     <= 1'b0;
         r_instr_q104     <= NOP;
         r_wb_q104        <= 32'd0;
         r_valid_q104     <= 1'b0;
      end else begin
         r_instr_q104 <= r_instr_q103;
         r_valid_q104 <= r_valid_q103;
         r_wb_q104    <= (r_instr_q103[6:0] == OP_LOAD) ? w_ld_data : r_alu_q103;
         r_instr_q103 <= r_instr_q102;
         r_valid_q103 <= r_valid_q102;
         r_alu_q103   <= w_res;
         r_st_q103    <= w_b;
         if (w_taken) begin
            r_pc_q100        <= w_target;
            InstructionQ101H <= NOP;
            r_valid_q101     <= 1'b0;
            r_instr_q102     <= NOP;
            r_valid_q102     <= 1'b0;
         end else if (w_stall) begin
            r_instr_q102 <= NOP;
            r_valid_q102 <= 1'b0;
         end else begin
            r_pc_q100        <= r_pc_q100 + 32'd4;
            InstructionQ101H <= w_fetch;
            r_pc_q101        <= r_pc_q100;
            r_valid_q101     <= 1'b1;
            r_instr_q102     <= InstructionQ101H;
            r_pc_q102        <= r_pc_q101;
            r_rs1_q102       <= w_rf_rs1;
            r_rs2_q102       <= w_rf_rs2;
            r_valid_q102     <= r_valid_q101;
         end
      end
   end

endmodule

// File: tb/tb_rvc_asap_top_5pl.sv
// Directed program bench: hand-assembled RV32I image, checks memory/register results and timing.
module tb_rvc_asap_top_5pl;

   logic Clock = 1'b0;
   logic Rst   = 1'b1;
   int   n_checks = 0;
   int   n_errors = 0;

   localparam logic [6:0] LUI  = 7'b0110111;
   localparam logic [6:0] IMM  = 7'b0010011;
   localparam logic [6:0] LOAD = 7'b0000011;

   rvc_asap_top_5pl dut (.Clock(Clock), .Rst(Rst));

   always #5 Clock = ~Clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
      return {imm, rs1, f3, rd, op};
   endfunction
   function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3);
      return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
   endfunction
   function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3);
      return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
   endfunction
   function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd, input logic [6:0] op);
      return {imm, rd, op};
   endfunction
   function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
      return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
   endfunction
   function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd);
      return {f7, rs2, rs1, f3, rd, 7'b0110011};
   endfunction

   function automatic logic [31:0] dword(input int a);
      return {dut.DMem[a+3], dut.DMem[a+2], dut.DMem[a+1], dut.DMem[a]};
   endfunction

   logic [31:0] prog [36];
   int          cyc;
   logic        seen;

   initial begin
      prog[0]  = enc_u(20'h00001, 5'd3, LUI);              // x3 = 0x1000
      prog[1]  = enc_i(12'd5, 5'd0, 3'b000, 5'd1, IMM);
      prog[2]  = enc_i(12'd7, 5'd1, 3'b000, 5'd2, IMM);     // x2 = 12
      prog[3]  = enc_s(12'h000, 5'd2, 5'd3, 3'b010);
      prog[4]  = enc_i(12'h000, 5'd3, 3'b010, 5'd4, LOAD);
      prog[5]  = enc_r(7'h00, 5'd4, 5'd4, 3'b000, 5'd5);    // load-use
      prog[6]  = enc_s(12'h004, 5'd5, 5'd3, 3'b010);
      prog[7]  = enc_b(13'd12, 5'd0, 5'd0, 3'b000);
      prog[8]  = enc_i(12'd1, 5'd0, 3'b000, 5'd6, IMM);
      prog[9]  = enc_i(12'd2, 5'd0, 3'b000, 5'd6, IMM);
      prog[10] = enc_s(12'h008, 5'd6, 5'd3, 3'b010);
      prog[11] = enc_i(12'h080, 5'd0, 3'b000, 5'd7, IMM);
      prog[12] = enc_s(12'h010, 5'd7, 5'd3, 3'b000);        // SB
      prog[13] = enc_i(12'h010, 5'd3, 3'b000, 5'd8, LOAD);  // LB
      prog[14] = enc_i(12'h010, 5'd3, 3'b100, 5'd9, LOAD);  // LBU
      prog[15] = enc_s(12'h020, 5'd8, 5'd3, 3'b010);
      prog[16] = enc_s(12'h024, 5'd9, 5'd3, 3'b010);
      prog[17] = enc_u(20'h0000C, 5'd10, LUI);
      prog[18] = enc_i(12'hEEF, 5'd10, 3'b000, 5'd10, IMM); // x10 = 0xBEEF
      prog[19] = enc_s(12'h012, 5'd10, 5'd3, 3'b001);       // SH
      prog[20] = enc_i(12'hFFD, 5'd0, 3'b000, 5'd11, IMM);  // x11 = -3
      prog[21] = enc_i(12'h000, 5'd11, 3'b010, 5'd12, IMM); // SLTI
      prog[22] = enc_i(12'd5, 5'd11, 3'b011, 5'd13, IMM);   // SLTIU
      prog[23] = enc_i(12'h401, 5'd11, 3'b101, 5'd14, IMM); // SRAI 1
      prog[24] = enc_i(12'd28, 5'd11, 3'b101, 5'd15, IMM);  // SRLI 28
      prog[25] = enc_r(7'h20, 5'd2, 5'd1, 3'b000, 5'd16);   // SUB
      prog[26] = enc_s(12'h030, 5'd12, 5'd3, 3'b010);
      prog[27] = enc_s(12'h034, 5'd13, 5'd3, 3'b010);
      prog[28] = enc_s(12'h038, 5'd14, 5'd3, 3'b010);
      prog[29] = enc_s(12'h03C, 5'd15, 5'd3, 3'b010);
      prog[30] = enc_s(12'h040, 5'd16, 5'd3, 3'b010);
      prog[31] = enc_j(21'd8, 5'd17);
      prog[32] = enc_i(12'h055, 5'd0, 3'b000, 5'd17, IMM);
      prog[33] = enc_s(12'h044, 5'd17, 5'd3, 3'b010);
      prog[34] = enc_s(12'hFFC, 5'd2, 5'd3, 3'b010);        // into IMem window: dropped
      prog[35] = 32'h0010_0073;

      for (int i = 0; i < 4096; i++) dut.IMem[i] = ((i % 4) == 0) ? 8'h13 : 8'h00;
      for (int i = 0; i < 36; i++)
         for (int k = 0; k < 4; k++) dut.IMem[4*i+k] = prog[i][8*k +: 8];
      for (int a = 'h1000; a <= 'h1FFF; a++) dut.DMem[a] = 8'hAA;

      for (int i = 0; i < 4; i++) begin
         @(posedge Clock); #1;
         chk("rst_pc", dut.r_pc_q100, 32'd0);
         chk("rst_q101", dut.InstructionQ101H, 32'h0000_0013);
      end
      @(negedge Clock);
      Rst = 1'b0;

      cyc  = 0;
      seen = 1'b0;
      while (!seen && cyc < 200) begin
         @(posedge Clock); #1;
         cyc++;
         if (cyc == 1) begin
            chk("first_fetch", dut.InstructionQ101H, 32'h0000_11B7);
            chk("pc_after_fetch", dut.r_pc_q100, 32'd4);
         end
         if (dut.InstructionQ101H == 32'h0010_0073) seen = 1'b1;
      end
      chk("ebreak_seen", {31'd0, seen}, 32'd1);
      chk("ebreak_cycle", cyc, 32'd38);

      repeat (6) @(posedge Clock);
      #1;
      chk("sw_fwd", dword('h1000), 32'h0000_000C);
      chk("load_use", dword('h1004), 32'h0000_0018);
      chk("br_flush", dword('h1008), 32'h0000_0000);
      chk("sb_sh", dword('h1010), 32'hBEEF_AA80);
      chk("lb_sext", dword('h1020), 32'hFFFF_FF80);
      chk("lbu_zext", dword('h1024), 32'h0000_0080);
      chk("slti", dword('h1030), 32'h0000_0001);
      chk("sltiu", dword('h1034), 32'h0000_0000);
      chk("srai", dword('h1038), 32'hFFFF_FFFE);
      chk("srli", dword('h103C), 32'h0000_000F);
      chk("sub", dword('h1040), 32'hFFFF_FFF9);
      chk("jal_link", dword('h1044), 32'h0000_0080);
      chk("imem_ro", {dut.IMem[4095], dut.IMem[4094], dut.IMem[4093], dut.IMem[4092]}, 32'h0000_0013);
      chk("untouched", dword('h1048), 32'hAAAA_AAAA);
      chk("x6_flushed", dut.r_regs[6], 32'd0);
      chk("x9_lbu", dut.r_regs[9], 32'h0000_0080);

      @(negedge Clock);
      Rst = 1'b1;
      @(posedge Clock); #1;
      chk("midrst_pc", dut.r_pc_q100, 32'd0);
      chk("midrst_q101", dut.InstructionQ101H, 32'h0000_0013);
      chk("midrst_dmem", dword('h1004), 32'h0000_0018);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
